// File: rtl/qpimem_page_splitter_pkg.sv
// qpimem_page_splitter_pkg: shared types and widths for the page-splitting write conditioner
package qpimem_page_splitter_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int SPLIT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int page_off_w(input int page_bytes);
        return $clog2(page_bytes);
    endfunction

endpackage

// File: rtl/qpimem_page_splitter.sv
// qpimem_page_splitter: forwards write bursts to qpimem_arb, splitting them at PSRAM page boundaries
module qpimem_page_splitter
    import qpimem_page_splitter_pkg::*;
#(
    parameter int PAGE_BYTES = 1024,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   up_do_write,
    output logic                   up_next_word,
    input  logic [ADDR_W-1:0]      up_addr,
    input  logic [DATA_W-1:0]      up_wdata,
    output logic                   arb_do_write,
    input  logic                   arb_next_word,
    output logic [ADDR_W-1:0]      arb_addr,
    output logic [DATA_W-1:0]      arb_wdata,
    input  logic                   clr_stats,
    output logic                   busy,
    output logic [SPLIT_CNT_W-1:0] split_count,
    output logic                   err_one_word
);

    localparam int OFF_W = page_off_w(PAGE_BYTES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(PAGE_BYTES - 4);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cur_addr, cur_addr_nx;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nx;
    logic              gap_drop, gap_drop_nx;
    logic              do_write, ack, split_inc, err_set;
    logic [ADDR_W-1:0] addr_mux;
    logic              up_off_last, cur_off_last, gap_done, gap_abort;

    assign up_off_last  = up_addr[OFF_W-1:0] == LAST_OFF;
    assign cur_off_last = cur_addr[OFF_W-1:0] == LAST_OFF;
    assign gap_done     = gap_cnt <= GAP_W'(1);
    assign gap_abort    = gap_drop || !up_do_write;

    // next-state, address and handshake decode; consumption only counts while a request is presented
    always_comb begin
        state_nx    = state;
        cur_addr_nx = cur_addr;
        gap_cnt_nx  = gap_cnt;
        gap_drop_nx = gap_drop;
        do_write    = 1'b0;
        ack         = 1'b0;
        addr_mux    = cur_addr;
        split_inc   = 1'b0;
        err_set     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                do_write = up_do_write;
                addr_mux = up_addr;
                ack      = up_do_write && arb_next_word;
                err_set  = up_do_write && up_off_last;
                if (ack) begin
                    cur_addr_nx = up_addr + 32'd4;
                    state_nx    = up_off_last ? ST_GAP : ST_PASS;
                    gap_cnt_nx  = up_off_last ? GAP_LOAD : gap_cnt;
                    gap_drop_nx = 1'b0;
                end
            end
            ST_PASS: begin
                do_write = up_do_write;
                ack      = up_do_write && arb_next_word;
                if (!up_do_write) begin
                    state_nx = ST_IDLE;
                end else if (ack) begin
                    cur_addr_nx = cur_addr + 32'd4;
                    if (cur_off_last) begin
                        state_nx    = ST_GAP;
                        gap_cnt_nx  = GAP_LOAD;
                        gap_drop_nx = 1'b0;
                        split_inc   = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_nx  = (gap_cnt != '0) ? gap_cnt - GAP_W'(1) : '0;
                gap_drop_nx = gap_abort;
                if (gap_done) state_nx = gap_abort ? ST_IDLE : ST_PASS;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign arb_do_write = reset && do_write;
    assign up_next_word = reset && ack;
    assign arb_addr     = addr_mux;
    assign arb_wdata    = up_wdata;
    assign busy         = state != ST_IDLE;

    // burst state, running address and gap timer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cur_addr <= '0;
            gap_cnt  <= '0;
            gap_drop <= 1'b0;
        end else begin
            state    <= state_nx;
            cur_addr <= cur_addr_nx;
            gap_cnt  <= gap_cnt_nx;
            gap_drop <= gap_drop_nx;
        end
    end

    // statistics: saturating split counter and sticky one-word flag, clear wins over updates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            split_count  <= '0;
            err_one_word <= 1'b0;
        end else if (clr_stats) begin
            split_count  <= '0;
            err_one_word <= 1'b0;
        end else begin
            if (split_inc && split_count != '1) split_count <= split_count + 1'b1;
            if (err_set) err_one_word <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qpimem_page_splitter.sv
// tb_qpimem_page_splitter: table-driven burst vectors plus hand sequences for reset and stale-ack cases
module tb_qpimem_page_splitter;

    logic        clk, reset;
    logic        up_do_write, up_next_word;
    logic [31:0] up_addr, up_wdata;
    logic        arb_do_write, arb_next_word;
    logic [31:0] arb_addr, arb_wdata;
    logic        clr_stats, busy, err_one_word;
    logic [15:0] split_count;
    logic        auto_ack, ack_force;

    int checks = 0;
    int errors = 0;

    qpimem_page_splitter #(.PAGE_BYTES(1024), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .up_do_write(up_do_write), .up_next_word(up_next_word),
        .up_addr(up_addr), .up_wdata(up_wdata),
        .arb_do_write(arb_do_write), .arb_next_word(arb_next_word),
        .arb_addr(arb_addr), .arb_wdata(arb_wdata),
        .clr_stats(clr_stats), .busy(busy),
        .split_count(split_count), .err_one_word(err_one_word)
    );

    assign arb_next_word = ack_force || (auto_ack && arb_do_write);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        int          n;
        int          gaps;
        int          splits;
        logic        err;
        logic [31:0] last;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [31:0] wd(input int i);
        return 32'hA500_0000 ^ 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input logic [31:0] a, input int n, input bit stop_gap,
                             output int acks, output int low, output int runs,
                             output int bad, output logic [31:0] last, output bit hit);
        int cyc;
        bit prev_low;
        logic [31:0] exp_a;
        acks = 0; low = 0; runs = 0; bad = 0; last = '0; hit = 0; cyc = 0; prev_low = 0;
        up_addr = a;
        up_wdata = wd(0);
        up_do_write = 1'b1;
        while (acks < n && cyc < 5000 && !hit) begin
            @(negedge clk);
            cyc++;
            if (!arb_do_write) begin
                low++;
                if (!prev_low) runs++;
            end
            prev_low = !arb_do_write;
            if (stop_gap && !arb_do_write) begin
                hit = 1;
            end else begin
                if (up_next_word) begin
                    exp_a = a + 32'(acks) * 32'd4;
                    if (arb_addr !== exp_a || arb_wdata !== wd(acks)) bad++;
                    last = arb_addr;
                    acks++;
                end
                tick();
                if (acks == n) up_do_write = 1'b0;
                else up_wdata = wd(acks);
            end
        end
        if (!stop_gap) up_do_write = 1'b0;
    endtask

    initial begin
        int acks, low, runs, bad;
        logic [31:0] last;
        bit hit;

        tbl[0] = '{32'h0000_1000,   8, 0,  0, 1'b0, 32'h0000_101C};
        tbl[1] = '{32'h0000_13F0,   8, 1,  1, 1'b0, 32'h0000_140C};
        tbl[2] = '{32'h0000_13FC,   2, 1, -1, 1'b1, 32'h0000_1400};
        tbl[3] = '{32'h0000_0000, 600, 2,  2, 1'b0, 32'h0000_095C};
        tbl[4] = '{32'hFFFF_FFF0,   6, 1,  1, 1'b0, 32'h0000_0004};

        reset = 1'b0; up_do_write = 1'b1; up_addr = 32'h13FC; up_wdata = '0;
        clr_stats = 1'b0; auto_ack = 1'b0; ack_force = 1'b1;
        #3;
        chk("rst_arb_do_write", 32'(arb_do_write), 32'd0);
        chk("rst_up_next_word", 32'(up_next_word), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_split_count", 32'(split_count), 32'd0);
        chk("rst_err", 32'(err_one_word), 32'd0);
        up_do_write = 1'b0; ack_force = 1'b0; up_addr = '0;
        tick();
        reset = 1'b1;
        auto_ack = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            clr_stats = 1'b1;
            tick();
            clr_stats = 1'b0;
            chk($sformatf("v%0d_clr_split", i), 32'(split_count), 32'd0);
            run_burst(tbl[i].addr, tbl[i].n, 1'b0, acks, low, runs, bad, last, hit);
            tick();
            tick();
            @(negedge clk);
            chk($sformatf("v%0d_acks", i), 32'(acks), 32'(tbl[i].n));
            chk($sformatf("v%0d_addr_data_bad", i), 32'(bad), 32'd0);
            chk($sformatf("v%0d_last_addr", i), last, tbl[i].last);
            chk($sformatf("v%0d_gap_runs", i), 32'(runs), 32'(tbl[i].gaps));
            chk($sformatf("v%0d_low_cycles", i), 32'(low), 32'(2 * tbl[i].gaps));
            if (tbl[i].splits >= 0)
                chk($sformatf("v%0d_split_count", i), 32'(split_count), 32'(tbl[i].splits));
            chk($sformatf("v%0d_err", i), 32'(err_one_word), 32'(tbl[i].err));
            chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
        end

        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        run_burst(32'h0000_13F0, 8, 1'b1, acks, low, runs, bad, last, hit);
        chk("rst_mid_gap_reached", 32'(hit), 32'd1);
        chk("rst_mid_split_before", 32'(split_count), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_arb_do_write", 32'(arb_do_write), 32'd0);
        chk("rst_mid_up_next_word", 32'(up_next_word), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        tick();
        up_do_write = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_split_after", 32'(split_count), 32'd0);
        chk("rst_mid_busy_after", 32'(busy), 32'd0);
        tick();
        run_burst(32'h0000_2000, 4, 1'b0, acks, low, runs, bad, last, hit);
        chk("post_rst_acks", 32'(acks), 32'd4);
        chk("post_rst_bad", 32'(bad), 32'd0);
        chk("post_rst_last", last, 32'h0000_200C);
        chk("post_rst_low", 32'(low), 32'd0);
        tick();
        tick();

        auto_ack = 1'b0;
        up_addr = 32'h0000_13F8;
        up_wdata = wd(7);
        up_do_write = 1'b1;
        ack_force = 1'b1;
        @(negedge clk);
        chk("stale_idle_addr", arb_addr, 32'h0000_13F8);
        chk("stale_idle_nw", 32'(up_next_word), 32'd1);
        tick();
        clr_stats = 1'b1;
        @(negedge clk);
        chk("stale_pass_addr", arb_addr, 32'h0000_13FC);
        chk("stale_pass_nw", 32'(up_next_word), 32'd1);
        tick();
        clr_stats = 1'b0;
        @(negedge clk);
        chk("clr_vs_split", 32'(split_count), 32'd0);
        chk("gap1_do_write", 32'(arb_do_write), 32'd0);
        chk("gap1_nw", 32'(up_next_word), 32'd0);
        chk("gap1_addr", arb_addr, 32'h0000_1400);
        tick();
        @(negedge clk);
        chk("gap2_nw", 32'(up_next_word), 32'd0);
        chk("gap2_addr", arb_addr, 32'h0000_1400);
        chk("gap2_busy", 32'(busy), 32'd1);
        ack_force = 1'b0;
        tick();
        @(negedge clk);
        chk("restart_do_write", 32'(arb_do_write), 32'd1);
        chk("restart_addr", arb_addr, 32'h0000_1400);
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        @(negedge clk);
        chk("restart_next_addr", arb_addr, 32'h0000_1404);
        up_do_write = 1'b0;
        tick();
        @(negedge clk);
        chk("stale_end_busy", 32'(busy), 32'd0);
        chk("stale_end_split", 32'(split_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
